mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge system clock.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: instr  in  32  current instruction register contents.
REQ-004 SHALL have port: zero  in  1  ALU equality flag (A == B).
REQ-005 SHALL have port: mem_ready  in  1  memory handshake completion for the current request.
REQ-006 SHALL have ports: pc_we, ir_we, reg_we, mem_req, mem_we, out, 1 each; active-high strobes.
REQ-007 SHALL have port: ext_ctrl  out  3  immediate extender mode (EXT_zero / EXT_sign / EXT_loadUpper / EXT_brOffset).
REQ-008 SHALL have ports: alu_op out 2 (0 add, 1 sub, 2 or, 3 pass-B); alu_src_b out 1 (0 reg, 1 imm32); reg_dst out 1 (0 rt, 1 rd); wd_sel out 1 (0 ALU, 1 mem); pc_sel out 2 (0 PC+4, 1 branch, 2 jump); iaddr_sel out 1 (0 PC, 1 ALU result).
REQ-009 SHALL have ports: state out 3, illegal out 1, retired out 32 (instructions completed).

Function
REQ-010 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6-7 SHALL map to FETCH on the next edge.
REQ-011 In FETCH, SHALL hold mem_req=1, mem_we=0, iaddr_sel=0; on mem_ready=1, pulse ir_we=1 and pc_we=1 with pc_sel=0, and go to DECODE; otherwise stay in FETCH with the strobes low.
REQ-012 SHALL decode the supported set: addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02.
REQ-013 In DECODE, SHALL drive ext_ctrl: ori -> EXT_zero; lw/sw -> EXT_sign; lui -> EXT_loadUpper; beq -> EXT_brOffset; other instructions -> EXT_zero.
REQ-014 ext_ctrl SHALL hold that value from DECODE through the last state of the instruction.
REQ-015 In DECODE, for j: SHALL pulse pc_we with pc_sel=2, increment retired, and go to FETCH.
REQ-016 In DECODE, for an unsupported opcode/funct: SHALL go to HALT.
REQ-017 In DECODE, for all other supported instructions: SHALL go to EXEC.
REQ-018 In EXEC, SHALL set alu_op: addu/lw/sw -> add; subu/beq -> sub; ori -> or; lui -> pass-B.
REQ-019 In EXEC, SHALL set alu_src_b=1 for ori/lui/lw/sw and alu_src_b=0 otherwise.
REQ-020 In EXEC, for beq: SHALL pulse pc_we with pc_sel=1 if zero=1, increment retired, and go to FETCH.
REQ-021 In EXEC, lw/sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-022 In MEM, SHALL hold mem_req=1, iaddr_sel=1, and mem_we=1 for sw only.
REQ-023 In MEM, on mem_ready: sw SHALL increment retired and go to FETCH; lw SHALL go to WB.
REQ-024 In MEM, the controller SHALL stay in MEM until mem_ready=1.
REQ-025 In WB, SHALL pulse reg_we=1; reg_dst=1 for addu/subu, else 0; wd_sel=1 for lw, else 0.
REQ-026 In WB, SHALL increment retired and go to FETCH.
REQ-027 In HALT, SHALL hold illegal=1 and all strobes 0 until reset.
REQ-028 All outputs SHALL be Moore functions of the state register and instr.
REQ-029 Latency with zero-wait memory SHALL be: j 2 cycles; beq 3; addu/subu/ori/lui/sw 4; lw 5. Each mem_ready-low cycle SHALL add 1.
REQ-030 mem_ready asserted outside FETCH/MEM SHALL be ignored.
REQ-031 instr SHALL be treated as stable except in the cycle that ir_we is high.
REQ-032 retired SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-033 While reset=0, state SHALL be FETCH, retired SHALL be 0, illegal SHALL be 0, all strobes SHALL be 0, and ext_ctrl SHALL be EXT_zero; this SHALL hold immediately, without a clock.
REQ-034 Reset asserted in any state, including mid-handshake in MEM, SHALL abort the instruction with no write strobe. After release, the first rising edge SHALL evaluate FETCH.

Structure
REQ-035 The state encodings, opcode/funct constants, alu_op/pc_sel codes and EXT_* codes SHALL reside in the shared macros include file.
REQ-036 SHALL instantiate one combinational sub-module, mc_decode (instr -> instruction class one-hot + legal flag). The state register, output logic and retired counter SHALL reside in mc_ctrl.

Verification
REQ-037 Bench SHALL cover: ori $1,$0,0x8001, zero-wait -> ext_ctrl=EXT_zero, alu_op=or, reg_we pulse in cycle 4, reg_dst=0, retired 0->1.
REQ-038 Bench SHALL cover: lw with mem_ready low for 3 MEM cycles -> mem_req held 4 cycles in MEM, ext_ctrl=EXT_sign, reg_we/wd_sel=1 in cycle 8, total 8 cycles.
REQ-039 Bench SHALL cover: beq with zero=1, then beq with zero=0 -> pc_we+pc_sel=1 in cycle 3 for the first only; both retire; ext_ctrl=EXT_brOffset.
REQ-040 Bench SHALL cover: instr=0xFC000000 -> HALT after DECODE, illegal=1, no further pc_we or mem_req for 20 cycles; retired unchanged.
REQ-041 Bench SHALL cover: reset=0 asserted mid-MEM of sw -> mem_we and mem_req drop without a clock edge; after release, state=FETCH and retired=0.
REQ-042 Bench SHALL cover: retired preloaded to 0xFFFFFFFF via force, then lui -> retired wraps to 0; ext_ctrl=EXT_loadUpper, alu_op=pass-B.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU/PC/extender codes.
// The decoder and the controller both import this package, so the two cannot disagree.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    st_fetch  = 3'd0,
    st_decode = 3'd1,
    st_exec   = 3'd2,
    st_mem    = 3'd3,
    st_wb     = 3'd4,
    st_halt   = 3'd5
  } state_t;

  localparam logic [5:0] op_rtype = 6'h00;
  localparam logic [5:0] op_ori   = 6'h0d;
  localparam logic [5:0] op_lui   = 6'h0f;
  localparam logic [5:0] op_lw    = 6'h23;
  localparam logic [5:0] op_sw    = 6'h2b;
  localparam logic [5:0] op_beq   = 6'h04;
  localparam logic [5:0] op_j     = 6'h02;
  localparam logic [5:0] fn_addu  = 6'h21;
  localparam logic [5:0] fn_subu  = 6'h23;

  localparam logic [2:0] ext_zero       = 3'd0;
  localparam logic [2:0] ext_sign       = 3'd1;
  localparam logic [2:0] ext_loadupper  = 3'd2;
  localparam logic [2:0] ext_broffset   = 3'd3;

  localparam logic [1:0] alu_add   = 2'd0;
  localparam logic [1:0] alu_sub   = 2'd1;
  localparam logic [1:0] alu_or    = 2'd2;
  localparam logic [1:0] alu_passb = 2'd3;

  localparam logic [1:0] pc_plus4  = 2'd0;
  localparam logic [1:0] pc_branch = 2'd1;
  localparam logic [1:0] pc_jump   = 2'd2;

  // One-hot instruction class; all-zero means the instruction is not supported.
  typedef struct packed {
    logic j;
    logic beq;
    logic sw;
    logic lw;
    logic lui;
    logic ori;
    logic subu;
    logic addu;
  } iclass_t;

  function automatic logic [2:0] ext_mode(input iclass_t c);
    if (c.lw || c.sw) return ext_sign;
    if (c.lui)        return ext_loadupper;
    if (c.beq)        return ext_broffset;
    return ext_zero;
  endfunction

  function automatic logic [1:0] alu_mode(input iclass_t c);
    if (c.subu || c.beq) return alu_sub;
    if (c.ori)           return alu_or;
    if (c.lui)           return alu_passb;
    return alu_add;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> one-hot class plus legal flag.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls,
  output logic        legal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  // Register/immediate fields never influence control.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    cls      = '0;
    cls.addu = (op == op_rtype) && (funct == fn_addu);
    cls.subu = (op == op_rtype) && (funct == fn_subu);
    cls.ori  = (op == op_ori);
    cls.lui  = (op == op_lui);
    cls.lw   = (op == op_lw);
    cls.sw   = (op == op_sw);
    cls.beq  = (op == op_beq);
    cls.j    = (op == op_j);
    legal    = |cls;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// with a retired-instruction counter. Reset is asynchronous and active low.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  ext_ctrl,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic        reg_dst,
  output logic        wd_sel,
  output logic [1:0]  pc_sel,
  output logic        iaddr_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state_reg, state_next;
  logic [31:0] retired_reg;
  logic        retire;
  iclass_t     cls;
  logic        legal;

  mc_decode u_decode (
    .instr (instr),
    .cls   (cls),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= st_fetch;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) retired_reg <= retired_reg + 32'd1;
    end
  end

  always_comb begin
    state_next = st_fetch;
    retire     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ext_ctrl   = ext_zero;
    alu_op     = alu_add;
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    wd_sel     = 1'b0;
    pc_sel     = pc_plus4;
    iaddr_sel  = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      st_fetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = st_decode;
        end else begin
          state_next = st_fetch;
        end
      end
      st_decode: begin
        ext_ctrl = ext_mode(cls);
        if (cls.j) begin
          pc_we      = 1'b1;
          pc_sel     = pc_jump;
          retire     = 1'b1;
          state_next = st_fetch;
        end else if (!legal) begin
          state_next = st_halt;
        end else begin
          state_next = st_exec;
        end
      end
      st_exec: begin
        ext_ctrl  = ext_mode(cls);
        alu_op    = alu_mode(cls);
        alu_src_b = cls.ori | cls.lui | cls.lw | cls.sw;
        if (cls.beq) begin
          retire     = 1'b1;
          state_next = st_fetch;
          if (zero) begin
            pc_we  = 1'b1;
            pc_sel = pc_branch;
          end
        end else if (cls.lw || cls.sw) begin
          state_next = st_mem;
        end else begin
          state_next = st_wb;
        end
      end
      // ALU controls stay valid through MEM/WB so the address and result remain stable.
      st_mem: begin
        ext_ctrl  = ext_mode(cls);
        alu_op    = alu_mode(cls);
        alu_src_b = 1'b1;
        mem_req   = 1'b1;
        iaddr_sel = 1'b1;
        mem_we    = cls.sw;
        if (!mem_ready)  state_next = st_mem;
        else if (cls.sw) begin
          retire     = 1'b1;
          state_next = st_fetch;
        end else         state_next = st_wb;
      end
      st_wb: begin
        ext_ctrl   = ext_mode(cls);
        alu_op     = alu_mode(cls);
        alu_src_b  = cls.ori | cls.lui | cls.lw | cls.sw;
        reg_we     = 1'b1;
        reg_dst    = cls.addu | cls.subu;
        wd_sel     = cls.lw;
        retire     = 1'b1;
        state_next = st_fetch;
      end
      st_halt: begin
        illegal    = 1'b1;
        state_next = st_halt;
      end
      default: state_next = st_fetch;
    endcase
    // Reset must silence every strobe at once, before the state register is even sampled.
    if (!reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed, table-driven bench for mc_ctrl: per-cycle expected outputs are
// hand-derived; reset, illegal-halt and counter-wrap corners run as sequences.
module tb_mc_ctrl;

  localparam logic [31:0] I_ORI  = 32'h3401_8001; // ori  $1,$0,0x8001
  localparam logic [31:0] I_ADDU = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] I_SUBU = 32'h0022_2023; // subu $4,$1,$2
  localparam logic [31:0] I_ADD  = 32'h0022_1820; // add (unsupported funct)
  localparam logic [31:0] I_LW   = 32'h8C05_0004; // lw   $5,4($0)
  localparam logic [31:0] I_SW   = 32'hAC05_0008; // sw   $5,8($0)
  localparam logic [31:0] I_BEQ  = 32'h1021_0002; // beq  $1,$1,2
  localparam logic [31:0] I_J    = 32'h0800_0100; // j    0x100
  localparam logic [31:0] I_LUI  = 32'h3C06_1234; // lui  $6,0x1234
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_we, ir_we, reg_we, mem_req, mem_we;
  logic [2:0]  ext_ctrl;
  logic [1:0]  alu_op;
  logic        alu_src_b, reg_dst, wd_sel;
  logic [1:0]  pc_sel;
  logic        iaddr_sel;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic        mr, z;
    logic [2:0]  st;
    logic        pcwe, irwe, regwe, mreq, mwe;
    logic [2:0]  ext;
    logic [1:0]  aop;
    logic        asrc, rdst, wds;
    logic [1:0]  psel;
    logic        isel, ill;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ext_ctrl  (ext_ctrl),
    .alu_op    (alu_op),
    .alu_src_b (alu_src_b),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .pc_sel    (pc_sel),
    .iaddr_sel (iaddr_sel),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] i, input int mr, input int z, input int st,
                              input int pcwe, input int irwe, input int regwe, input int mreq,
                              input int mwe, input int ext, input int aop, input int asrc,
                              input int rdst, input int wds, input int psel, input int isel,
                              input int ill, input int ret);
    vec_t v;
    v.instr = i;           v.mr   = 1'(mr);    v.z     = 1'(z);
    v.st    = 3'(st);      v.pcwe = 1'(pcwe);  v.irwe  = 1'(irwe);
    v.regwe = 1'(regwe);   v.mreq = 1'(mreq);  v.mwe   = 1'(mwe);
    v.ext   = 3'(ext);     v.aop  = 2'(aop);   v.asrc  = 1'(asrc);
    v.rdst  = 1'(rdst);    v.wds  = 1'(wds);   v.psel  = 2'(psel);
    v.isel  = 1'(isel);    v.ill  = 1'(ill);   v.ret   = 32'(ret);
    return v;
  endfunction

  task automatic check(input vec_t v, input string name);
    logic [19:0] got, want;
    got  = {state, pc_we, ir_we, reg_we, mem_req, mem_we, ext_ctrl, alu_op,
            alu_src_b, reg_dst, wd_sel, pc_sel, iaddr_sel, illegal};
    want = {v.st, v.pcwe, v.irwe, v.regwe, v.mreq, v.mwe, v.ext, v.aop,
            v.asrc, v.rdst, v.wds, v.psel, v.isel, v.ill};
    n_checks++;
    if (got !== want || retired !== v.ret) begin
      n_fail++;
      $display("FAIL %s: outputs=%05h retired=%08h, required outputs=%05h retired=%08h",
               name, got, retired, want, v.ret);
    end else begin
      $display("%s: state=%0d outputs=%05h retired=%0d", name, state, got, retired);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and sample outputs just after.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    instr     = v.instr;
    mem_ready = v.mr;
    zero      = v.z;
    #1;
    check(v, name);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;

    // ori: FETCH, DECODE, EXEC(or), WB(reg_we)
    tbl.push_back(mk(I_ORI ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 0));
    tbl.push_back(mk(I_ORI ,0,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0));
    tbl.push_back(mk(I_ORI ,0,0, 2,0,0,0,0,0, 0,2,1,0,0, 0,0,0, 0));
    tbl.push_back(mk(I_ORI ,0,0, 4,0,0,1,0,0, 0,2,1,0,0, 0,0,0, 0));
    // addu with one fetch wait; mem_ready outside FETCH/MEM ignored
    tbl.push_back(mk(I_ADDU,0,0, 0,0,0,0,1,0, 0,0,0,0,0, 0,0,0, 1));
    tbl.push_back(mk(I_ADDU,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 1));
    tbl.push_back(mk(I_ADDU,1,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1));
    tbl.push_back(mk(I_ADDU,1,0, 2,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1));
    tbl.push_back(mk(I_ADDU,0,0, 4,0,0,1,0,0, 0,0,0,1,0, 0,0,0, 1));
    // subu; zero=1 must not cause a branch for a non-beq
    tbl.push_back(mk(I_SUBU,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(I_SUBU,0,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(I_SUBU,0,1, 2,0,0,0,0,0, 0,1,0,0,0, 0,0,0, 2));
    tbl.push_back(mk(I_SUBU,0,0, 4,0,0,1,0,0, 0,1,0,1,0, 0,0,0, 2));
    // j retires from DECODE
    tbl.push_back(mk(I_J   ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 3));
    tbl.push_back(mk(I_J   ,0,0, 1,1,0,0,0,0, 0,0,0,0,0, 2,0,0, 3));
    // lw with three MEM wait cycles: 8 cycles total
    tbl.push_back(mk(I_LW  ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 4));
    tbl.push_back(mk(I_LW  ,0,0, 1,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 4));
    tbl.push_back(mk(I_LW  ,1,0, 2,0,0,0,0,0, 1,0,1,0,0, 0,0,0, 4));
    tbl.push_back(mk(I_LW  ,0,0, 3,0,0,0,1,0, 1,0,1,0,0, 0,1,0, 4));
    tbl.push_back(mk(I_LW  ,0,0, 3,0,0,0,1,0, 1,0,1,0,0, 0,1,0, 4));
    tbl.push_back(mk(I_LW  ,0,0, 3,0,0,0,1,0, 1,0,1,0,0, 0,1,0, 4));
    tbl.push_back(mk(I_LW  ,1,0, 3,0,0,0,1,0, 1,0,1,0,0, 0,1,0, 4));
    tbl.push_back(mk(I_LW  ,0,0, 4,0,0,1,0,0, 1,0,1,0,1, 0,0,0, 4));
    // sw zero-wait retires from MEM
    tbl.push_back(mk(I_SW  ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 5));
    tbl.push_back(mk(I_SW  ,0,0, 1,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 5));
    tbl.push_back(mk(I_SW  ,0,0, 2,0,0,0,0,0, 1,0,1,0,0, 0,0,0, 5));
    tbl.push_back(mk(I_SW  ,1,0, 3,0,0,0,1,1, 1,0,1,0,0, 0,1,0, 5));
    // beq taken, then beq not taken
    tbl.push_back(mk(I_BEQ ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 6));
    tbl.push_back(mk(I_BEQ ,0,1, 1,0,0,0,0,0, 3,0,0,0,0, 0,0,0, 6));
    tbl.push_back(mk(I_BEQ ,0,1, 2,1,0,0,0,0, 3,1,0,0,0, 1,0,0, 6));
    tbl.push_back(mk(I_BEQ ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 7));
    tbl.push_back(mk(I_BEQ ,0,0, 1,0,0,0,0,0, 3,0,0,0,0, 0,0,0, 7));
    tbl.push_back(mk(I_BEQ ,0,0, 2,0,0,0,0,0, 3,1,0,0,0, 0,0,0, 7));
    // unsupported funct halts after DECODE
    tbl.push_back(mk(I_ADD ,0,0, 0,0,0,0,1,0, 0,0,0,0,0, 0,0,0, 8));
    tbl.push_back(mk(I_ADD ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 8));
    tbl.push_back(mk(I_ADD ,0,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 8));
    tbl.push_back(mk(I_ADD ,1,0, 5,0,0,0,0,0, 0,0,0,0,0, 0,0,1, 8));

    // Reset state must appear before any clock edge.
    #1;
    check(mk('0,0,0, 0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0), "reset_initial");
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Illegal opcode: HALT holds for 20 cycles with retired frozen.
    pulse_reset();
    step(mk(I_J  ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 0), "ill_j_fetch");
    step(mk(I_J  ,0,0, 1,1,0,0,0,0, 0,0,0,0,0, 2,0,0, 0), "ill_j_decode");
    step(mk(I_BAD,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 1), "ill_fetch");
    step(mk(I_BAD,0,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1), "ill_decode");
    for (int i = 0; i < 20; i++)
      step(mk(I_BAD, i % 2, 1, 5,0,0,0,0,0, 0,0,0,0,0, 0,0,1, 1), $sformatf("halt%0d", i));

    // Reset mid-MEM of sw: strobes drop between clock edges.
    pulse_reset();
    step(mk(I_ORI,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 0), "rst_ori_fetch");
    step(mk(I_ORI,0,0, 1,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0), "rst_ori_decode");
    step(mk(I_ORI,0,0, 2,0,0,0,0,0, 0,2,1,0,0, 0,0,0, 0), "rst_ori_exec");
    step(mk(I_ORI,0,0, 4,0,0,1,0,0, 0,2,1,0,0, 0,0,0, 0), "rst_ori_wb");
    step(mk(I_SW ,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 1), "rst_sw_fetch");
    step(mk(I_SW ,0,0, 1,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 1), "rst_sw_decode");
    step(mk(I_SW ,0,0, 2,0,0,0,0,0, 1,0,1,0,0, 0,0,0, 1), "rst_sw_exec");
    step(mk(I_SW ,0,0, 3,0,0,0,1,1, 1,0,1,0,0, 0,1,0, 1), "rst_sw_mem");
    #2;
    reset = 1'b0;
    #1;
    check(mk(I_SW,0,0, 0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0), "rst_async_drop");
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(mk(I_SW,1,0, 0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0), "rst_held");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check(mk(I_SW,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 0), "rst_release_fetch");
    step(mk(I_SW,0,0, 1,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 0), "rst_first_edge");

    // Counter wrap: preload all-ones, then retire a lui.
    pulse_reset();
    @(negedge clk);
    force dut.retired_reg = 32'hFFFF_FFFF;
    #1;
    release dut.retired_reg;
    instr     = I_LUI;
    mem_ready = 1'b1;
    zero      = 1'b0;
    #1;
    check(mk(I_LUI,1,0, 0,1,1,0,1,0, 0,0,0,0,0, 0,0,0, 32'hFFFF_FFFF), "wrap_fetch");
    step(mk(I_LUI,0,0, 1,0,0,0,0,0, 2,0,0,0,0, 0,0,0, 32'hFFFF_FFFF), "wrap_decode");
    step(mk(I_LUI,0,0, 2,0,0,0,0,0, 2,3,1,0,0, 0,0,0, 32'hFFFF_FFFF), "wrap_exec");
    step(mk(I_LUI,0,0, 4,0,0,1,0,0, 2,3,1,0,0, 0,0,0, 32'hFFFF_FFFF), "wrap_wb");
    step(mk(I_LUI,0,0, 0,0,0,0,1,0, 0,0,0,0,0, 0,0,0, 0), "wrap_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
